// File: rtl/controlador_alarme_pkg.sv
// Shared types and constants for the multi-slot alarm scheduler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package controlador_alarme_pkg;

    localparam int LARG_HORA       = 12;
    localparam int T_TOQUE_PADRAO  = 60;
    localparam int T_SONECA_PADRAO = 300;

    typedef enum logic {
        VARRE_IDLE,
        VARRE_RUN
    } varre_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_TOCA,
        R_SONECA
    } toque_t;

endpackage

// File: rtl/comparador.sv
// Equality comparator for time words, shared by all alarm slots.
// Latency: combinational, zero cycles.
// Backpressure: none.
module comparador #(
    parameter int LARG = 12
) (
    input  logic [LARG-1:0] a,
    input  logic [LARG-1:0] b,
    output logic            eq
);

    assign eq = (a == b);

endmodule

// File: rtl/controlador_alarme.sv
// Alarm scheduler: scans N slots with one comparator per second and runs ring/snooze/stop.
// Latency: tick sampled at edge t -> achou at t+N+1 -> buzzer at t+N+2; buttons act on the next edge.
// Backpressure: none; writes accepted every cycle, ticks arriving mid-scan do not start a scan.
module controlador_alarme
    import controlador_alarme_pkg::*;
#(
    parameter int N_ALARMES = 4,
    parameter int T_TOQUE   = T_TOQUE_PADRAO,
    parameter int T_SONECA  = T_SONECA_PADRAO,
    localparam int LI       = $clog2(N_ALARMES),
    localparam int LC       = $clog2(T_SONECA)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_1s,
    input  logic [LARG_HORA-1:0] hora_atual,
    input  logic                 wr_en,
    input  logic [LI-1:0]        wr_idx,
    input  logic [LARG_HORA-1:0] wr_hora,
    input  logic                 wr_ativo,
    input  logic                 parar,
    input  logic                 soneca,
    output logic                 buzzer,
    output logic [LI-1:0]        alarme_idx,
    output logic                 em_soneca
);

    // Slot register bank
    logic [LARG_HORA-1:0] hora [N_ALARMES];
    logic [N_ALARMES-1:0] ativo;
    logic [N_ALARMES-1:0] disparado;

    // Scan state
    varre_t        varre_q, varre_d;
    logic [LI-1:0] k_q, k_d;
    logic          cand_vld_q, cand_vld_d;
    logic [LI-1:0] cand_idx_q, cand_idx_d;
    logic          fim_q, fim_d;
    logic          achou_q;
    logic          eq;

    // Ring state
    toque_t        toque_q, toque_d;
    logic [LC-1:0] cnt_q, cnt_d, cnt_inc;
    logic [LI-1:0] idx_q, idx_d;
    logic          dispara;

    comparador #(.LARG(LARG_HORA)) u_comparador (
        .a  (hora_atual),
        .b  (hora[k_q]),
        .eq (eq)
    );

    // Scan sequencing: step k across slots, keep the lowest eligible match
    always_comb begin
        varre_d    = varre_q;
        k_d        = k_q;
        cand_vld_d = cand_vld_q;
        cand_idx_d = cand_idx_q;
        fim_d      = 1'b0;
        case (varre_q)
            VARRE_IDLE: begin
                if (tick_1s) begin
                    varre_d    = VARRE_RUN;
                    k_d        = '0;
                    cand_vld_d = 1'b0;
                    cand_idx_d = '0;
                end
            end
            VARRE_RUN: begin
                if (eq && ativo[k_q] && !disparado[k_q] && !cand_vld_q) begin
                    cand_vld_d = 1'b1;
                    cand_idx_d = k_q;
                end
                if (k_q == LI'(N_ALARMES - 1)) begin
                    varre_d = VARRE_IDLE;
                    fim_d   = 1'b1;
                end else begin
                    k_d = k_q + LI'(1);
                end
            end
            default: varre_d = VARRE_IDLE;
        endcase
    end

    // Scan registers; achou is issued the cycle after the last slot is compared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            varre_q    <= VARRE_IDLE;
            k_q        <= '0;
            cand_vld_q <= 1'b0;
            cand_idx_q <= '0;
            fim_q      <= 1'b0;
            achou_q    <= 1'b0;
        end else begin
            varre_q    <= varre_d;
            k_q        <= k_d;
            cand_vld_q <= cand_vld_d;
            cand_idx_q <= cand_idx_d;
            fim_q      <= fim_d;
            achou_q    <= fim_q && cand_vld_q;
        end
    end

    // Ring/snooze decisions; parar beats soneca and any timeout
    always_comb begin
        toque_d = toque_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dispara = 1'b0;
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + LC'(1);
        case (toque_q)
            R_IDLE: begin
                if (achou_q) begin
                    toque_d = R_TOCA;
                    idx_d   = cand_idx_q;
                    cnt_d   = '0;
                    dispara = 1'b1;
                end
            end
            R_TOCA: begin
                if (parar) begin
                    toque_d = R_IDLE;
                end else if (soneca) begin
                    toque_d = R_SONECA;
                    cnt_d   = '0;
                end else if (tick_1s) begin
                    if (cnt_q == LC'(T_TOQUE - 1)) toque_d = R_IDLE;
                    else                           cnt_d   = cnt_inc;
                end
            end
            R_SONECA: begin
                if (parar) begin
                    toque_d = R_IDLE;
                end else if (tick_1s) begin
                    if (cnt_q == LC'(T_SONECA - 1)) begin
                        toque_d = R_TOCA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: toque_d = R_IDLE;
        endcase
    end

    // Ring registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toque_q <= R_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            toque_q <= toque_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Slot bank: mismatch clears fired flag, ring start sets it, a write clears it last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ALARMES; i++) hora[i] <= '0;
            ativo     <= '0;
            disparado <= '0;
        end else begin
            if (varre_q == VARRE_RUN && !eq) disparado[k_q] <= 1'b0;
            if (dispara)                     disparado[cand_idx_q] <= 1'b1;
            if (wr_en) begin
                hora[wr_idx]      <= wr_hora;
                ativo[wr_idx]     <= wr_ativo;
                disparado[wr_idx] <= 1'b0;
            end
        end
    end

    assign buzzer     = (toque_q == R_TOCA);
    assign em_soneca  = (toque_q == R_SONECA);
    assign alarme_idx = idx_q;

endmodule

// File: tb/tb_controlador_alarme.sv
// Self-checking bench for controlador_alarme against a per-second behavioural model.
// Latency: model predicts achou N+2 edges after an accepted tick.
// Backpressure: not applicable.
module tb_controlador_alarme;

    localparam int N  = 4;
    localparam int TT = 60;
    localparam int TS = 300;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick_1s, wr_en, wr_ativo, parar, soneca;
    logic [11:0] hora_atual, wr_hora;
    logic [1:0]  wr_idx;
    logic        buzzer, em_soneca;
    logic [1:0]  alarme_idx;

    controlador_alarme #(.N_ALARMES(N), .T_TOQUE(TT), .T_SONECA(TS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1s    (tick_1s),
        .hora_atual (hora_atual),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_hora    (wr_hora),
        .wr_ativo   (wr_ativo),
        .parar      (parar),
        .soneca     (soneca),
        .buzzer     (buzzer),
        .alarme_idx (alarme_idx),
        .em_soneca  (em_soneca)
    );

    always #5 clk = ~clk;

    // Behavioural model: alarm table plus a "mode + ticks remaining" view of the ringer
    logic [11:0] m_hora [N];
    bit          m_ativo [N];
    bit          m_disp [N];
    int          m_modo;      // 0 quiet, 1 ringing, 2 snoozing
    int          m_resta;     // ticks left in the current ring/snooze phase
    int          m_idx;
    int          cyc = 0;
    int          ult_scan;
    int          achou_em;
    int          achou_slot;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_vec++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, esp, cyc);
        end
    endtask

    task automatic modelo_reset();
        for (int i = 0; i < N; i++) begin
            m_hora[i]  = '0;
            m_ativo[i] = 0;
            m_disp[i]  = 0;
        end
        m_modo   = 0;
        m_resta  = 0;
        m_idx    = 0;
        ult_scan = -1000;
        achou_em = -1;
    endtask

    task automatic modelo_passo();
        int c;
        cyc++;
        if (achou_em == cyc && m_modo == 0) begin
            m_modo  = 1;
            m_resta = TT;
            m_idx   = achou_slot;
            m_disp[achou_slot] = 1;
        end else if (m_modo == 1) begin
            if (parar) m_modo = 0;
            else if (soneca) begin
                m_modo  = 2;
                m_resta = TS;
            end else if (tick_1s) begin
                m_resta--;
                if (m_resta == 0) m_modo = 0;
            end
        end else if (m_modo == 2) begin
            if (parar) m_modo = 0;
            else if (tick_1s) begin
                m_resta--;
                if (m_resta == 0) begin
                    m_modo  = 1;
                    m_resta = TT;
                end
            end
        end
        if (achou_em == cyc) achou_em = -1;
        if (wr_en) begin
            m_hora[wr_idx]  = wr_hora;
            m_ativo[wr_idx] = wr_ativo;
            m_disp[wr_idx]  = 0;
        end
        if (tick_1s && cyc > ult_scan + N) begin
            ult_scan = cyc;
            c = -1;
            for (int i = 0; i < N; i++) begin
                if (m_hora[i] != hora_atual) m_disp[i] = 0;
                else if (m_ativo[i] && !m_disp[i] && c < 0) c = i;
            end
            if (c >= 0) begin
                achou_em   = cyc + N + 2;
                achou_slot = c;
            end
        end
    endtask

    task automatic confere();
        verifica("buzzer", buzzer, m_modo == 1);
        verifica("em_soneca", em_soneca, m_modo == 2);
        verifica("alarme_idx", alarme_idx, m_idx);
    endtask

    // One clock: drive at negedge, model at posedge, check at next negedge
    task automatic passo(input bit tk, input bit pa, input bit so, input bit we,
                         input int wi, input logic [11:0] wh, input bit wa);
        tick_1s  = tk;
        parar    = pa;
        soneca   = so;
        wr_en    = we;
        wr_idx   = 2'(wi);
        wr_hora  = wh;
        wr_ativo = wa;
        @(posedge clk);
        modelo_passo();
        @(negedge clk);
        confere();
    endtask

    task automatic ocioso(input int n);
        for (int i = 0; i < n; i++) passo(0, 0, 0, 0, 0, 12'h000, 0);
    endtask

    task automatic segundo(input int gap);
        passo(1, 0, 0, 0, 0, 12'h000, 0);
        ocioso(gap - 1);
    endtask

    task automatic escreve(input int i, input logic [11:0] h, input bit a);
        passo(0, 0, 0, 1, i, h, a);
    endtask

    task automatic aperta_parar();
        passo(0, 1, 0, 0, 0, 12'h000, 0);
    endtask

    task automatic limpa_slots();
        for (int i = 0; i < N; i++) escreve(i, 12'h000, 0);
    endtask

    initial begin
        int lat;
        tick_1s = 0; parar = 0; soneca = 0; wr_en = 0; wr_idx = 0;
        wr_hora = 0; wr_ativo = 0; hora_atual = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        verifica("reset_buzzer", buzzer, 0);
        verifica("reset_soneca", em_soneca, 0);
        verifica("reset_idx", alarme_idx, 0);
        modelo_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Basic ring with first-ring latency
        escreve(2, 12'h123, 1);
        hora_atual = 12'h123;
        passo(1, 0, 0, 0, 0, 12'h000, 0);
        lat = 0;
        for (int j = 0; j < 20 && !buzzer; j++) begin
            ocioso(1);
            lat++;
        end
        verifica("latencia_toque", lat, N + 2);
        verifica("idx_basico", alarme_idx, 2);
        aperta_parar();
        verifica("parar_desliga", buzzer, 0);

        // Priority among matches, inactive slot skipped
        escreve(0, 12'h200, 0);
        escreve(1, 12'h200, 1);
        escreve(2, 12'h000, 0);
        escreve(3, 12'h200, 1);
        hora_atual = 12'h200;
        segundo(N + 4);
        verifica("prio_buzzer", buzzer, 1);
        verifica("prio_idx", alarme_idx, 1);
        aperta_parar();
        escreve(1, 12'h200, 0);
        segundo(N + 4);
        verifica("prio_idx_seguinte", alarme_idx, 3);
        aperta_parar();

        // Auto-stop after 60 ticks, no re-trigger while the time keeps matching
        limpa_slots();
        escreve(2, 12'h123, 1);
        hora_atual = 12'h123;
        segundo(N + 3);
        for (int j = 1; j <= 70; j++) begin
            segundo(N + 3);
            verifica($sformatf("auto_stop_tick%0d", j), buzzer, j < TT);
        end
        hora_atual = 12'h124;
        segundo(N + 3);
        hora_atual = 12'h123;
        segundo(N + 4);
        verifica("reativa_apos_mudanca", buzzer, 1);

        // Snooze, snooze expiry, counter restart, parar+soneca together
        passo(0, 0, 1, 0, 0, 12'h000, 0);
        verifica("soneca_buzzer", buzzer, 0);
        verifica("soneca_flag", em_soneca, 1);
        for (int j = 1; j <= TS; j++) begin
            segundo(N + 2);
            if (j >= TS - 1) verifica($sformatf("soneca_tick%0d", j), buzzer, j == TS);
        end
        for (int j = 1; j <= TT; j++) begin
            segundo(N + 2);
            if (j >= TT - 1) verifica($sformatf("retoque_tick%0d", j), buzzer, j < TT);
        end
        escreve(2, 12'h123, 1);
        segundo(N + 4);
        verifica("toque_antes_ambos", buzzer, 1);
        passo(0, 1, 1, 0, 0, 12'h000, 0);
        verifica("ambos_buzzer", buzzer, 0);
        verifica("ambos_soneca", em_soneca, 0);

        // Writes landing while slot 0 is being compared
        limpa_slots();
        escreve(0, 12'h300, 1);
        hora_atual = 12'h301;
        passo(1, 0, 0, 0, 0, 12'h000, 0);
        escreve(0, 12'h301, 1);
        ocioso(N + 3);
        verifica("escrita_valor_antigo", buzzer, 0);
        segundo(N + 4);
        verifica("escrita_valor_novo", buzzer, 1);
        verifica("escrita_idx", alarme_idx, 0);
        aperta_parar();
        segundo(N + 4);
        verifica("disparado_bloqueia", buzzer, 0);
        passo(1, 0, 0, 0, 0, 12'h000, 0);
        escreve(0, 12'h301, 1);
        ocioso(N + 3);
        verifica("reescrita_mesmo_scan", buzzer, 0);
        segundo(N + 4);
        verifica("reescrita_limpa_disparado", buzzer, 1);
        aperta_parar();

        // Randomized traffic; writes kept out of the compare window
        for (int i = 0; i < N; i++) escreve(i, 12'h100 + 12'(i), 1);
        for (int it = 0; it < 80; it++) begin
            int p;
            p = N + 2 + $urandom_range(0, 3);
            hora_atual = 12'h100 + 12'($urandom_range(0, 3));
            passo(1, $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0, 0, 0, 12'h000, 0);
            for (int m = 1; m < p; m++) begin
                bit we;
                we = (m >= N) && ($urandom_range(0, 2) == 0);
                passo(0, $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0, we,
                      $urandom_range(0, N - 1), 12'h100 + 12'($urandom_range(0, 3)),
                      $urandom_range(0, 3) != 0);
            end
        end
        aperta_parar();

        // Asynchronous reset while ringing
        limpa_slots();
        escreve(1, 12'h050, 1);
        hora_atual = 12'h050;
        segundo(N + 4);
        verifica("pre_reset_toca", buzzer, 1);
        #2 rst_n = 1'b0;
        #1;
        verifica("reset_async_buzzer", buzzer, 0);
        verifica("reset_async_idx", alarme_idx, 0);
        modelo_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) segundo(N + 4);
        verifica("sem_toque_pos_reset", buzzer, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
